// File: rtl/sumador_param_display_pkg.sv
// rtl/sumador_param_display_pkg.sv - shared segment codes and operation encodings
package sumador_param_display_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba codes, entry 15 first so SEG_HEX[n] selects digit n
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/sumador_param_display_seg7_hex_encoder.sv
// rtl/sumador_param_display_seg7_hex_encoder.sv - combinational nibble to active-low 7-segment encoder
module seg7_hex_encoder
    import sumador_param_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/sumador_param_display.sv
// rtl/sumador_param_display.sv - pipelined add/sub with scanned hex display; option LEADING_ZERO_BLANK_EN
module sumador_param_display
    import sumador_param_display_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              Op,
    input  logic              Start,
    output logic [WIDTH:0]    Q,
    output logic              Done,
    output logic [6:0]        Seg,
    output logic [DIGITS-1:0] An
);

    localparam int DW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [WIDTH-1:0] a_r, b_r;
    op_e              op_r;
    logic             cap_r;
    logic [WIDTH:0]   res;

    // Operands are zero-extended so the top bit is carry on add and borrow (A<B) on sub
    always_comb begin
        res = {1'b0, a_r} + {1'b0, b_r};
        if (op_r == OP_SUB) begin
            res = {1'b0, a_r} - {1'b0, b_r};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= OP_ADD;
            cap_r <= 1'b0;
            Q     <= '0;
            Done  <= 1'b0;
        end else begin
            cap_r <= Start;
            Done  <= cap_r;
            if (Start) begin
                a_r  <= A;
                b_r  <= B;
                op_r <= op_e'(Op);
            end
            if (cap_r) begin
                Q <= res;
            end
        end
    end

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    logic [DW-1:0]     disp;
    logic [3:0]        nib;
    logic [6:0]        enc_seg;
    logic              blank;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] an_next;

    assign disp = DW'(Q);
    assign nib  = disp[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [DW-1:0] upper;
    // A digit is a leading zero when it and every more-significant nibble are zero
    assign upper = disp >> {idx, 2'b00};
    assign blank = (idx != '0) && (upper == '0);
`else
    assign blank = 1'b0;
`endif

    seg7_hex_encoder u_enc (
        .nibble (nib),
        .seg    (enc_seg)
    );

    assign seg_next = blank ? SEG_BLANK : enc_seg;
    assign an_next  = ~(DIGITS'(1) << idx);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Seg <= SEG_BLANK;
            An  <= '1;
        end else begin
            Seg <= seg_next;
            An  <= an_next;
        end
    end

endmodule

// File: tb/tb_sumador_param_display.sv
// tb/tb_sumador_param_display.sv - randomized and directed checks against a behavioural model
module tb_sumador_param_display;

    localparam int WIDTH    = 8;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic [WIDTH-1:0]  A = '0;
    logic [WIDTH-1:0]  B = '0;
    logic              Op = 1'b0;
    logic              Start = 1'b0;
    logic [WIDTH:0]    Q;
    logic              Done;
    logic [6:0]        Seg;
    logic [DIGITS-1:0] An;

    sumador_param_display #(
        .WIDTH    (WIDTH),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .Start (Start),
        .Q     (Q),
        .Done  (Done),
        .Seg   (Seg),
        .An    (An)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    int q_m     = 0;
    int res_m   = 0;
    bit cap_m   = 0;
    int edges_m = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int arith(input int a, input int b, input bit op);
        if (!op) return a + b;
        return ((a - b) & 255) | ((a < b) ? 256 : 0);
    endfunction

    function automatic logic [6:0] seg_of(input int q, input int d);
        int n, hi;
        n  = (q >> (4 * d)) & 15;
        hi = q >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && hi == 0) return 7'h7F;
`endif
        return hex_tab[n];
    endfunction

    task automatic tick();
        int d;
        logic [6:0] es;
        logic [2:0] ea;
        bit ed;
        @(posedge Clk);
        d  = (edges_m / SCAN_DIV) % DIGITS;
        es = seg_of(q_m, d);
        ea = 3'(~(1 << d));
        ed = cap_m;
        if (cap_m) q_m = res_m;
        cap_m = Start;
        if (Start) res_m = arith(int'(A), int'(B), Op);
        edges_m++;
        @(negedge Clk);
        check("q", 32'(Q), 32'(q_m));
        check("done", 32'(Done), 32'(ed));
        check("seg", 32'(Seg), 32'(es));
        check("an", 32'(An), 32'(ea));
    endtask

    task automatic do_op(input int a, input int b, input bit op);
        A = 8'(a); B = 8'(b); Op = op; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        tick();
        check("first_an", 32'(An), 32'h6);
        check("first_seg", 32'(Seg), 32'h40);

        do_op('hFF, 'h01, 1'b0);
        tick();
        check("carry_q", 32'(Q), 32'h100);
        do_op('h05, 'h07, 1'b1);
        check("borrow_q", 32'(Q), 32'h1FE);
        do_op('h07, 'h05, 1'b1);
        check("sub_q", 32'(Q), 32'h002);

        A = 8'h10; B = 8'h20; Op = 1'b0; Start = 1'b1; tick();
        A = 8'h30; B = 8'h10; Op = 1'b1; tick();
        A = 8'hFF; B = 8'hFF; Op = 1'b0; tick();
        Start = 1'b0; tick();
        tick();
        check("b2b_q", 32'(Q), 32'h1FE);

        repeat (14) tick();
        do_op('h02, 'h03, 1'b0);
        repeat (14) tick();
        check("small_q", 32'(Q), 32'h005);

        #2 Rst = 1'b1;
        #1;
        check("rst_q", 32'(Q), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        check("rst_seg", 32'(Seg), 32'h7F);
        check("rst_an", 32'(An), 32'h7);
        A = 8'h11; B = 8'h22; Op = 1'b0; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("rst_hold_q", 32'(Q), 32'h0);
        check("rst_hold_done", 32'(Done), 32'h0);
        check("rst_hold_an", 32'(An), 32'h7);
        Start = 1'b0;
        Rst   = 1'b0;
        q_m = 0; res_m = 0; cap_m = 0; edges_m = 0;
        tick();
        check("rel_an", 32'(An), 32'h6);
        check("rel_seg", 32'(Seg), 32'h40);

        for (int i = 0; i < 400; i++) begin
            A     = 8'($urandom);
            B     = 8'($urandom);
            Op    = 1'($urandom);
            Start = ($urandom_range(0, 2) != 0);
            tick();
        end
        Start = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
